uart_tx_gen: RTL and testbench
==============================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port data_i  input  DATA_W  word to transmit.
REQ-008 SHALL have port valid_i  input  1  data_i valid request.
REQ-009 SHALL have port ready_o  output  1  block can accept a word this cycle.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-014 SHALL assert ready_o combinationally exactly when state is IDLE.
REQ-015 SHALL accept a word on a rising edge where valid_i=1 and ready_o=1; it SHALL latch data_i and enter START on that edge.
REQ-016 SHALL ignore valid_i and data_i in every state other than IDLE; post-accept changes to data_i SHALL NOT affect the frame.
REQ-017 SHALL drive tx from a register, so tx goes low on the edge after acceptance (1-cycle latency).
REQ-018 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that clears on every bit boundary.
REQ-019 SHALL transmit, in order: start bit 0; DATA_W data bits LSB first; one parity bit only when PARITY!=0; STOP_BITS stop bits at 1.
REQ-020 SHALL compute the parity bit from the latched word: even mode gives XOR of the bits, odd mode gives its inverse.
REQ-021 SHALL make the total frame length (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first tx-low cycle.
REQ-022 SHALL transition START->DATA, DATA->PAR (or STOP when PARITY=0) after bit DATA_W-1, PAR->STOP, and STOP->IDLE after the final stop-bit period.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL pulse done high for exactly one cycle, the first IDLE cycle after STOP; ready_o is also high in that cycle.
REQ-025 SHALL allow back-to-back frames: valid_i=1 during the done cycle is accepted, giving no idle gap beyond that one cycle.
REQ-026 SHALL hold tx at 1 throughout IDLE.
REQ-027 SHALL size the bit index counter as clog2(DATA_W+1) and the baud counter as clog2(CLKS_PER_BIT); neither SHALL wrap within a frame.

Reset
REQ-028 SHALL, on rst, immediately force state=IDLE, tx=1, busy=0, done=0, ready_o=1, and clear all counters and the latched word.
REQ-029 SHALL abort a frame when rst is asserted mid-frame; after release, tx stays 1 until a new word is accepted.
REQ-030 SHALL NOT accept a word in any cycle where rst is high.

Verification
REQ-031 SHALL cover the default case: data_i=8'hA5, 1-cycle valid_i -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; done pulses at cycle 160.
REQ-032 SHALL cover PARITY=2, CLKS_PER_BIT=4, data_i=8'h07 -> parity bit 1, frame is 44 cycles; with PARITY=1 the parity bit is 0.
REQ-033 SHALL cover DATA_W=5, STOP_BITS=2, CLKS_PER_BIT=4, data_i=5'h1F -> frame is 32 cycles and the last 8 cycles are tx=1.
REQ-034 SHALL cover back-to-back words 8'h00 then 8'hFF with valid_i held high -> second start bit begins 1 cycle after done; the second word is not corrupted.
REQ-035 SHALL cover valid_i pulsing while busy with data_i changing -> transmitted bits match the originally latched word, and no extra frame is sent.
REQ-036 SHALL cover rst asserted during bit 3 of DATA -> tx=1, busy=0 asynchronously; after release, the next accepted word is transmitted as a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_gen.sv
// UART transmitter: sends a parallel word as a start bit, DATA_W data bits LSB first,
// an optional parity bit and STOP_BITS stop bits, each held for CLKS_PER_BIT clocks.
module uart_tx_gen #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int IDX_W  = $clog2(DATA_W + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int SEL_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Even mode makes the total count of ones even; odd mode inverts that.
    function automatic logic parity_bit(input logic [DATA_W-1:0] word);
        logic p;
        p = ^word;
        if (PARITY == 1) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [BAUD_W-1:0]   baud_r, baud_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                tx_r, tx_s;
    logic                done_r, done_s;
    logic                bit_end_s;

    // State, counters, latched word and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            baud_r  <= '0;
            data_r  <= '0;
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            baud_r  <= baud_s;
            data_r  <= data_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; the baud counter restarts at every bit boundary.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        baud_s    = baud_r;
        data_s    = data_r;
        done_s    = 1'b0;
        bit_end_s = (baud_r == BAUD_LAST);
        case (state_r)
            IDLE: begin
                if (valid_i) begin
                    state_s = START;
                    data_s  = data_i;
                    idx_s   = '0;
                    baud_s  = '0;
                end else begin
                    baud_s  = '0;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    idx_s   = '0;
                    baud_s  = '0;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (idx_r == DATA_LAST) begin
                        idx_s   = '0;
                        state_s = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            PAR: begin
                if (bit_end_s) begin
                    state_s = STOP;
                    idx_s   = '0;
                    baud_s  = '0;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (idx_r == STOP_LAST) begin
                        idx_s   = '0;
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = '0;
                baud_s  = '0;
            end
        endcase
    end

    // Line value for the coming cycle, derived from where the FSM is heading.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = data_r[idx_s[SEL_W-1:0]];
            PAR:     tx_s = parity_bit(data_r);
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    assign ready_o = (state_r == IDLE);
    assign busy    = (state_r != IDLE);
    assign tx      = tx_r;
    assign done    = done_r;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: four configurations run in parallel, each compared cycle by cycle
// against a queue of expected line values built from the frame format.
module tb_uart_tx_gen;

    localparam int CFG_DW  [4] = '{8, 8, 8, 5};
    localparam int CFG_CPB [4] = '{16, 4, 4, 4};
    localparam int CFG_PAR [4] = '{0, 2, 1, 0};
    localparam int CFG_SB  [4] = '{1, 1, 1, 2};
    localparam int CFG_W0  [4] = '{32'hA5, 32'h07, 32'h07, 32'h1F};

    logic clk = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int DW   = CFG_DW[g];
        localparam int CPB  = CFG_CPB[g];
        localparam int PAR  = CFG_PAR[g];
        localparam int SB   = CFG_SB[g];
        localparam int FLEN = (1 + DW + ((PAR != 0) ? 1 : 0) + SB) * CPB;

        logic          rst;
        logic [DW-1:0] data;
        logic          valid;
        logic          ready, tx, busy, done;
        bit            exp_q[$];
        bit            done_exp = 1'b0;
        bit            fin = 1'b0;

        uart_tx_gen #(
            .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(SB)
        ) dut (
            .clk(clk), .rst(rst), .data_i(data), .valid_i(valid),
            .ready_o(ready), .tx(tx), .busy(busy), .done(done)
        );

        // Expands a word into its per-cycle line values.
        function automatic void push_frame(input logic [DW-1:0] w);
            bit bits[$];
            int ones;
            ones = 0;
            bits.push_back(1'b0);
            for (int i = 0; i < DW; i++) begin
                bits.push_back(w[i]);
                ones += int'(w[i]);
            end
            if (PAR == 2) bits.push_back(bit'(ones % 2));
            else if (PAR == 1) bits.push_back(bit'(1 - (ones % 2)));
            for (int s = 0; s < SB; s++) bits.push_back(1'b1);
            foreach (bits[k]) for (int c = 0; c < CPB; c++) exp_q.push_back(bits[k]);
        endfunction

        task automatic cycle(input bit v, input logic [DW-1:0] d);
            bit et;
            et = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            check_val($sformatf("c%0d tx", g), tx, et);
            check_val($sformatf("c%0d ready", g), ready, exp_q.size() == 0);
            check_val($sformatf("c%0d busy", g), busy, exp_q.size() != 0);
            check_val($sformatf("c%0d done", g), done, done_exp);
            valid = v;
            data  = d;
            @(posedge clk);
            if (exp_q.size() != 0) begin
                exp_q.delete(0);
                done_exp = (exp_q.size() == 0);
            end else begin
                done_exp = 1'b0;
                if (v) push_frame(d);
            end
            @(negedge clk);
        endtask

        task automatic check_reset_outputs(input string tag);
            check_val($sformatf("c%0d %s tx", g, tag), tx, 1'b1);
            check_val($sformatf("c%0d %s busy", g, tag), busy, 1'b0);
            check_val($sformatf("c%0d %s done", g, tag), done, 1'b0);
            check_val($sformatf("c%0d %s ready", g, tag), ready, 1'b1);
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (busy === 1'b1 && n < 2 * FLEN) begin
                cycle(1'b0, '0);
                n++;
            end
            check_val($sformatf("c%0d drain", g), busy, 1'b0);
            cycle(1'b0, '0);
        endtask

        initial begin
            int n;
            rst   = 1'b1;
            valid = 1'b0;
            data  = '0;
            @(negedge clk);
            @(negedge clk);
            check_reset_outputs("reset");
            rst = 1'b0;
            cycle(1'b0, '0);

            // Directed frame, with its length measured from the first low cycle to done.
            cycle(1'b1, DW'(CFG_W0[g]));
            n = 0;
            while (done !== 1'b1 && n < 4 * FLEN) begin
                n++;
                cycle(1'b0, '0);
            end
            check_val($sformatf("c%0d frame_len", g), n, FLEN);
            cycle(1'b0, '0);

            // Back-to-back: all-zeros then all-ones with valid held high throughout.
            cycle(1'b1, '0);
            repeat (FLEN + 1) cycle(1'b1, '1);
            drain();

            // Random traffic, including valid pulses and data changes while busy.
            for (int i = 0; i < 50 * CPB; i++) begin
                cycle($urandom_range(0, 3) == 0, DW'($urandom));
            end
            drain();

            // Reset landing in data bit 3, with valid high during reset.
            cycle(1'b1, DW'($urandom));
            repeat (4 * CPB + 1) cycle(1'b0, '0);
            rst   = 1'b1;
            valid = 1'b1;
            data  = DW'($urandom);
            #1;
            check_reset_outputs("async_rst");
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("held_rst");
            exp_q.delete();
            done_exp = 1'b0;
            rst   = 1'b0;
            valid = 1'b0;
            repeat (2 * CPB) cycle(1'b0, '0);
            cycle(1'b1, DW'($urandom));
            repeat (FLEN + 3) cycle(1'b0, '0);
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60000) check_val("timeout", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
